// File: rtl/zap_decode_irq_sequencer.sv
// Decode-stage interrupt entry sequencer: drops the flagged micro-op and injects
// SAVE_LR / SAVE_PSR / JUMP into the shared decode output slot.
module zap_decode_irq_sequencer #(
    parameter logic [4:0] IRQ_VECTOR = 5'h18,
    parameter logic [4:0] FIQ_VECTOR = 5'h1C
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [34:0] i_instruction,
    input  logic        i_instruction_valid,
    input  logic        i_irq,
    input  logic        i_fiq,
    input  logic        i_irq_mask,
    input  logic        i_fiq_mask,
    input  logic        i_stall_from_upstream,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_issue_stall,
    output logic [34:0] o_instruction,
    output logic        o_instruction_valid,
    output logic [1:0]  o_uop_kind,
    output logic [4:0]  o_vector,
    output logic        o_hold_upstream,
    output logic        o_stall_from_decode,
    output logic        o_fiq_taken,
    output logic        o_irq_taken
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE_LR  = 2'd1,
        SAVE_PSR = 2'd2,
        JUMP     = 2'd3
    } state_t;

    localparam logic [1:0]  KIND_PASS     = 2'd0;
    localparam logic [1:0]  KIND_SAVE_LR  = 2'd1;
    localparam logic [1:0]  KIND_SAVE_PSR = 2'd2;
    localparam logic [1:0]  KIND_JUMP     = 2'd3;
    localparam logic [34:0] INJECTED_UOP  = {4'hE, 31'd0};

    state_t state, state_nxt;
    logic   src_ff, src_nxt;
    logic   fiq_taken_nxt, irq_taken_nxt;
    logic   take_fiq, take_irq, take_any;

    assign take_fiq = i_instruction_valid & i_fiq & ~i_fiq_mask;
    assign take_irq = i_instruction_valid & i_irq & ~i_irq_mask & ~take_fiq;
    assign take_any = take_fiq | take_irq;

    // Data stall outranks the ALU flush; writeback flush outranks everything but reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            src_ff      <= 1'b0;
            o_fiq_taken <= 1'b0;
            o_irq_taken <= 1'b0;
        end else if (i_clear_from_writeback) begin
            state       <= IDLE;
            o_fiq_taken <= 1'b0;
            o_irq_taken <= 1'b0;
        end else if (!i_data_stall) begin
            if (i_clear_from_alu) begin
                state       <= IDLE;
                o_fiq_taken <= 1'b0;
                o_irq_taken <= 1'b0;
            end else if (!(i_stall_from_shifter || i_issue_stall)) begin
                state       <= state_nxt;
                src_ff      <= src_nxt;
                o_fiq_taken <= fiq_taken_nxt;
                o_irq_taken <= irq_taken_nxt;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        src_nxt       = src_ff;
        fiq_taken_nxt = 1'b0;
        irq_taken_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (take_any) begin
                    state_nxt     = SAVE_LR;
                    src_nxt       = take_fiq;
                    fiq_taken_nxt = take_fiq;
                    irq_taken_nxt = take_irq;
                end
            end
            SAVE_LR:  state_nxt = SAVE_PSR;
            SAVE_PSR: state_nxt = JUMP;
            JUMP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_instruction       = '0;
        o_instruction_valid = 1'b0;
        o_uop_kind          = KIND_PASS;
        o_vector            = '0;
        o_hold_upstream     = 1'b1;
        o_stall_from_decode = 1'b1;
        case (state)
            IDLE: begin
                if (!take_any) begin
                    o_instruction       = i_instruction;
                    o_instruction_valid = i_instruction_valid;
                    o_hold_upstream     = 1'b0;
                    o_stall_from_decode = i_stall_from_upstream;
                end
            end
            SAVE_LR: begin
                o_instruction       = INJECTED_UOP;
                o_instruction_valid = 1'b1;
                o_uop_kind          = KIND_SAVE_LR;
            end
            SAVE_PSR: begin
                o_instruction       = INJECTED_UOP;
                o_instruction_valid = 1'b1;
                o_uop_kind          = KIND_SAVE_PSR;
            end
            JUMP: begin
                o_instruction       = INJECTED_UOP;
                o_instruction_valid = 1'b1;
                o_uop_kind          = KIND_JUMP;
                o_vector            = src_ff ? FIQ_VECTOR : IRQ_VECTOR;
            end
            default: ;
        endcase
    end

endmodule
